// File: rtl/decay_pair_recorder.sv
// -----------------------------------------------------------------------------
// decay_pair_recorder
//
// Measures the interval, in clk cycles, between two trigger pulses whose
// spacing does not exceed a programmable window. Each accepted pair produces
// a one-cycle double_trig pulse and pushes the interval into a small
// first-word-fall-through FIFO that the processor drains with rd_en.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   trigger      raw discriminator output, asynchronous to clk
//   window       maximum accepted interval in cycles, sampled every cycle
//   rd_en        pop strobe for the FIFO head
//   rd_data      FIFO head value, valid while empty=0
//   empty        FIFO empty flag
//   full         FIFO full flag
//   level        number of stored entries
//   double_trig  one-cycle pulse per accepted pair
//   overflow_cnt pairs dropped because the FIFO was full, saturating
// -----------------------------------------------------------------------------
module decay_pair_recorder #(
    parameter int CNT_W      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger,
    input  logic [CNT_W-1:0]      window,
    input  logic                  rd_en,
    output logic [CNT_W-1:0]      rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  double_trig,
    output logic [15:0]           overflow_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        IDLE,
        ARMED
    } state_t;

    logic                  q1, q2, q3;
    logic                  edge_det;
    state_t                state;
    logic [CNT_W-1:0]      cnt;

    logic [CNT_W-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  record, push, pop;
    logic [DEPTH_LOG2:0]   level_nxt;

    // Three-flop chain: q1/q2 resynchronise the asynchronous trigger, q3 gives
    // the previous level. Requiring q1&q2 rejects pulses shorter than 2 cycles.
    // NOTE: non-blocking assignments make every stage capture its predecessor's
    // old value, so the chain shifts exactly one stage per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1 <= 1'b0;
            q2 <= 1'b0;
            q3 <= 1'b0;
        end else begin
            q1 <= trigger;
            q2 <= q1;
            q3 <= q2;
        end
    end

    assign edge_det = q1 & q2 & ~q3;

    // A record is the second edge of a pair; the push happens on the same
    // clock edge that raises double_trig.
    assign record = (state == ARMED) && edge_det;
    assign pop    = rd_en & ~empty;
    // When full, a simultaneous pop frees the slot the new entry needs.
    assign push   = record & (~full | rd_en);

    // NOTE: default assignment first so every path assigns level_nxt and no
    // latch is inferred.
    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    // Pair FSM. cnt equals the number of cycles since the first edge, so the
    // value captured on the second edge is the interval directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            double_trig <= 1'b0;
        end else begin
            double_trig <= 1'b0;
            case (state)
                IDLE: begin
                    if (edge_det && (window != '0)) begin
                        state <= ARMED;
                        cnt   <= CNT_W'(1);
                    end
                end
                ARMED: begin
                    if (edge_det) begin
                        double_trig <= 1'b1;
                        state       <= IDLE;
                    end else if (cnt >= window) begin
                        // Live window: lowering it below cnt times out at once.
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers and registered flags, all derived from level_nxt so they
    // stay mutually consistent every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            empty <= (level_nxt == '0);
            full  <= (level_nxt == (DEPTH_LOG2+1)'(DEPTH));
        end
    end

    // NOTE: storage array is deliberately not reset; the pointers and flags
    // define which entries are valid, and the output is gated by empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cnt;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_cnt <= '0;
        end else if (record && full && !rd_en && (overflow_cnt != 16'hFFFF)) begin
            overflow_cnt <= overflow_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_decay_pair_recorder.sv
module tb_decay_pair_recorder;

    localparam int CNT_W      = 16;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                trigger;
    logic [CNT_W-1:0]    window;
    logic                rd_en;
    logic [CNT_W-1:0]    rd_data;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] level;
    logic                double_trig;
    logic [15:0]         overflow_cnt;

    always #5 clk = ~clk;

    decay_pair_recorder #(.CNT_W(CNT_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk          (clk),
        .rst          (rst),
        .trigger      (trigger),
        .window       (window),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .level        (level),
        .double_trig  (double_trig),
        .overflow_cnt (overflow_cnt)
    );

    int checks   = 0;
    int failures = 0;
    int dt_seen  = 0;

    // Reference model: trigger sample history, pair timestamps, FIFO as a queue.
    bit samp[$];
    bit m_armed;
    int m_cyc = 0;
    int m_t0;
    int mq[$];
    int m_ovf;
    bit m_dt;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called right after a rising clk edge with the inputs that edge saw.
    task automatic model_step();
        bit s1, s2, s3, e, rec;
        int n, val;
        m_cyc++;
        if (rst) begin
            samp.delete();
            m_armed = 0;
            mq.delete();
            m_ovf = 0;
            m_dt  = 0;
            return;
        end
        // A detected edge: trigger seen high on the two latest samples after a low one.
        n  = samp.size();
        s1 = (n >= 1) ? samp[n-1] : 1'b0;
        s2 = (n >= 2) ? samp[n-2] : 1'b0;
        s3 = (n >= 3) ? samp[n-3] : 1'b0;
        e  = s1 && s2 && !s3;
        rec = 0;
        val = 0;
        if (m_armed) begin
            if (e) begin
                rec = 1;
                val = m_cyc - m_t0;
                m_armed = 0;
            end else if (m_cyc - m_t0 >= int'(window)) begin
                m_armed = 0;
            end
        end else if (e && window != 0) begin
            m_armed = 1;
            m_t0 = m_cyc;
        end
        if (rd_en && mq.size() > 0) void'(mq.pop_front());
        if (rec) begin
            if (mq.size() < DEPTH) mq.push_back(val);
            else if (m_ovf < 65535) m_ovf++;
        end
        m_dt = rec;
        samp.push_back(trigger);
        if (samp.size() > 3) void'(samp.pop_front());
    endtask

    task automatic compare_all();
        check("double_trig", int'(double_trig), int'(m_dt));
        check("level", int'(level), mq.size());
        check("empty", int'(empty), int'(mq.size() == 0));
        check("full", int'(full), int'(mq.size() == DEPTH));
        check("overflow_cnt", int'(overflow_cnt), m_ovf);
        if (mq.size() > 0) check("rd_data", int'(rd_data), mq[0]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        if (double_trig) dt_seen++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic pulse(input int w);
        trigger = 1'b1;
        run(w);
        trigger = 1'b0;
    endtask

    // Two pulses whose rising edges are gap cycles apart.
    task automatic pair(input int gap, input int w1, input int w2);
        pulse(w1);
        run(gap - w1);
        pulse(w2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(2);
    endtask

    task automatic pop1();
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
    endtask

    task automatic fill16();
        for (int i = 0; i < DEPTH; i++) begin
            pair(10 + i, 2, 2);
            run(5);
        end
    endtask

    typedef struct {
        int win;
        int w1;
        int w2;
        int gap;
        int exp_dt;
        int exp_val;
    } vec_t;

    vec_t vecs[10];
    int   wins[5];

    initial begin
        int hold;
        vecs[0] = '{100,  2, 2, 40,  1, 40};
        vecs[1] = '{100,  2, 2, 100, 1, 100};
        vecs[2] = '{100,  2, 2, 101, 0, 0};
        vecs[3] = '{100,  2, 2, 3,   1, 3};
        vecs[4] = '{100,  1, 2, 20,  0, 0};
        vecs[5] = '{100,  2, 1, 20,  0, 0};
        vecs[6] = '{0,    2, 2, 10,  0, 0};
        vecs[7] = '{5,    2, 2, 5,   1, 5};
        vecs[8] = '{5,    2, 2, 6,   0, 0};
        vecs[9] = '{1000, 3, 3, 300, 1, 300};
        wins    = '{0, 4, 12, 25, 60};

        rst     = 1'b1;
        trigger = 1'b0;
        rd_en   = 1'b0;
        window  = 16'd100;
        cycle();
        check("reset_rd_data", int'(rd_data), 0);
        check("reset_empty", int'(empty), 1);
        check("reset_level", int'(level), 0);
        check("reset_ovf", int'(overflow_cnt), 0);
        cycle();
        rst = 1'b0;
        run(3);

        // Table-driven single pairs.
        for (int i = 0; i < 10; i++) begin
            window  = 16'(vecs[i].win);
            dt_seen = 0;
            pair(vecs[i].gap, vecs[i].w1, vecs[i].w2);
            run(vecs[i].win + 12);
            check($sformatf("vec%0d_dt", i), dt_seen, vecs[i].exp_dt);
            if (vecs[i].exp_dt != 0) begin
                check($sformatf("vec%0d_val", i), int'(rd_data), vecs[i].exp_val);
                check($sformatf("vec%0d_level", i), int'(level), 1);
                pop1();
            end else begin
                check($sformatf("vec%0d_level", i), int'(level), 0);
            end
        end

        // Interval 100 accepted, 101 re-arms, then 20 recorded.
        do_reset();
        window  = 16'd100;
        dt_seen = 0;
        pair(100, 2, 2);
        run(5);
        pulse(2);
        run(99);
        pulse(2);
        run(18);
        pulse(2);
        run(5);
        check("limit_dt", dt_seen, 2);
        check("limit_level", int'(level), 2);
        check("limit_first", int'(rd_data), 100);
        pop1();
        check("limit_second", int'(rd_data), 20);
        pop1();

        // Fill, overflow, drain.
        do_reset();
        fill16();
        check("fill_full", int'(full), 1);
        check("fill_level", int'(level), 16);
        dt_seen = 0;
        pair(50, 2, 2);
        run(5);
        check("ovf_dt", dt_seen, 1);
        check("ovf_cnt", int'(overflow_cnt), 1);
        check("ovf_level", int'(level), 16);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_val", int'(rd_data), 10 + i);
            pop1();
        end
        check("drain_empty", int'(empty), 1);

        // Full FIFO: record coincides with rd_en.
        do_reset();
        fill16();
        pulse(2);
        run(28);
        trigger = 1'b1;
        cycle();
        cycle();
        trigger = 1'b0;
        rd_en   = 1'b1;
        cycle();
        rd_en   = 1'b0;
        check("swap_dt", int'(double_trig), 1);
        check("swap_level", int'(level), 16);
        check("swap_ovf", int'(overflow_cnt), 0);
        check("swap_head", int'(rd_data), 11);
        for (int i = 0; i < DEPTH; i++) begin
            check("swap_drain", int'(rd_data), (i < 15) ? 11 + i : 30);
            pop1();
        end

        // Single-cycle glitches and reads while empty.
        do_reset();
        dt_seen = 0;
        for (int i = 0; i < 10; i++) begin
            pulse(1);
            run(9);
        end
        check("glitch_dt", dt_seen, 0);
        check("glitch_level", int'(level), 0);
        rd_en = 1'b1;
        run(3);
        rd_en = 1'b0;
        check("empty_rd_level", int'(level), 0);
        check("empty_rd_empty", int'(empty), 1);
        pair(30, 2, 2);
        run(3);
        check("after_empty_rd", int'(rd_data), 30);
        check("after_empty_lvl", int'(level), 1);

        // Reset while armed.
        do_reset();
        window  = 16'd1000;
        dt_seen = 0;
        pulse(2);
        run(498);
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(97);
        pulse(2);
        run(48);
        pulse(2);
        run(5);
        check("rstmid_dt", dt_seen, 1);
        check("rstmid_level", int'(level), 1);
        check("rstmid_val", int'(rd_data), 50);

        // Lowering window below cnt times out immediately.
        do_reset();
        window  = 16'd100;
        dt_seen = 0;
        pulse(2);
        run(48);
        window = 16'd20;
        run(10);
        window = 16'd100;
        pulse(2);
        run(23);
        pulse(2);
        run(5);
        check("live_dt", dt_seen, 1);
        check("live_val", int'(rd_data), 25);

        // Randomized traffic against the model.
        do_reset();
        window = 16'd25;
        hold   = 0;
        for (int i = 0; i < 8000; i++) begin
            if (hold == 0) begin
                if (trigger) begin
                    trigger = 1'b0;
                    hold = $urandom_range(1, 30);
                end else begin
                    trigger = 1'b1;
                    hold = $urandom_range(1, 3);
                end
            end
            hold--;
            rd_en = (i < 4000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 299) == 0) window = 16'(wins[$urandom_range(0, 4)]);
            rst = ($urandom_range(0, 1999) == 0);
            cycle();
        end
        rst   = 1'b0;
        rd_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
